// File: rtl/priority_encoder_stream.sv
// priority_encoder_stream: accepts a request vector and streams out the index
// of every set bit, one beat per cycle, in ascending (LSB_FIRST=1) or
// descending (LSB_FIRST=0) order. The last beat for a vector can overlap with
// acceptance of the next one, so back-to-back vectors produce no bubble.
//
// Optional feature macro: PRIORITY_ENCODER_STREAM_NULL_EN
//   defined   : an all-zero vector yields one beat with enc_nul=1, enc_lst=1
//   undefined : an all-zero vector is consumed silently, enc_nul tied low
//
// state | meaning
// IDLE  | mask empty, waiting for a request vector
// SCAN  | mask non-zero (or a null beat pending), emitting beats
module priority_encoder_stream #(
    parameter int WIDTH     = 16,
    parameter int SPLIT     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         dec_vld,
    input  logic                     dec_valid,
    output logic                     dec_ready,
    output logic [$clog2(WIDTH)-1:0] enc_idx,
    output logic                     enc_lst,
    output logic                     enc_nul,
    output logic                     enc_valid,
    input  logic                     enc_ready
);

    localparam int WIDTH_LOG = $clog2(WIDTH);
    localparam int NGRP      = (WIDTH + SPLIT - 1) / SPLIT;
    localparam int PADW      = NGRP * SPLIT;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_mask;
    logic [WIDTH-1:0]       w_mask_nxt;
    logic [PADW-1:0]        w_scan;
    logic [NGRP-1:0]        w_grp_any;
    logic                   w_any;
    logic [WIDTH_LOG-1:0]   w_pos;
    logic [WIDTH_LOG-1:0]   w_idx;
    logic [WIDTH-1:0]       w_sel;
    logic                   w_one;
    logic                   w_nul;
    logic                   w_out_xfer;
    logic                   w_in_xfer;

`ifdef PRIORITY_ENCODER_STREAM_NULL_EN
    logic                   r_nul;
    logic                   w_nul_nxt;
    assign w_nul = r_nul;
`else
    assign w_nul = 1'b0;
`endif

    // Put the mask into scan order (position 0 is scanned first), zero-padded
    // to a whole number of SPLIT-wide groups.
    always_comb begin
        w_scan = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_scan[i] = (LSB_FIRST != 0) ? r_mask[i] : r_mask[WIDTH-1-i];
        end
    end

    // First tree level: one OR per SPLIT-wide group.
    always_comb begin
        for (int g = 0; g < NGRP; g++) begin
            w_grp_any[g] = |w_scan[g*SPLIT +: SPLIT];
        end
    end

    // Second level: first non-empty group, then first set bit inside it.
    always_comb begin
        logic found;
        found = 1'b0;
        w_pos = '0;
        for (int g = 0; g < NGRP; g++) begin
            if (!found && w_grp_any[g]) begin
                found = 1'b1;
                for (int b = SPLIT - 1; b >= 0; b--) begin
                    if (w_scan[g*SPLIT+b]) begin
                        w_pos = WIDTH_LOG'(g * SPLIT + b);
                    end
                end
            end
        end
    end

    assign w_any = |w_grp_any;
    // Scan position maps back to a mask index; an empty mask reports index 0.
    assign w_idx = !w_any ? '0
                 : (LSB_FIRST != 0) ? w_pos
                 : (WIDTH_LOG'(WIDTH - 1) - w_pos);
    assign w_sel = WIDTH'(1) << w_idx;
    assign w_one = w_any && ((r_mask & (r_mask - WIDTH'(1))) == '0);

    assign enc_valid  = (r_state == ST_SCAN);
    assign enc_idx    = w_idx;
    assign enc_lst    = w_one | w_nul;
    assign enc_nul    = w_nul;
    assign w_out_xfer = enc_valid & enc_ready;
    assign dec_ready  = (r_state == ST_IDLE) | (w_out_xfer & enc_lst);
    assign w_in_xfer  = dec_valid & dec_ready;

    // Next state: retire the reported bit, then load a newly accepted vector
    // (which only happens when the mask is empty or just emptied).
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
`ifdef PRIORITY_ENCODER_STREAM_NULL_EN
        w_nul_nxt   = r_nul;
`endif
        if (w_out_xfer) begin
            w_mask_nxt = r_mask & ~w_sel;
`ifdef PRIORITY_ENCODER_STREAM_NULL_EN
            w_nul_nxt  = 1'b0;
`endif
            if (enc_lst) begin
                w_state_nxt = ST_IDLE;
            end
        end
        if (w_in_xfer) begin
            if (dec_vld != '0) begin
                w_mask_nxt  = dec_vld;
                w_state_nxt = ST_SCAN;
            end else begin
`ifdef PRIORITY_ENCODER_STREAM_NULL_EN
                w_nul_nxt   = 1'b1;
                w_state_nxt = ST_SCAN;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
        end
    end

    // State and mask registers; reset discards any scan in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
`ifdef PRIORITY_ENCODER_STREAM_NULL_EN
            r_nul   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
`ifdef PRIORITY_ENCODER_STREAM_NULL_EN
            r_nul   <= w_nul_nxt;
`endif
        end
    end

endmodule

// File: doc/priority_encoder_stream.md
PRIORITY_ENCODER_STREAM -- requirements
Module: priority_encoder_stream

Interface
REQ-001 Parameter WIDTH, default 16: request vector width; SHALL be >= 2.
REQ-002 Parameter SPLIT, default 4: fan-in of the internal priority encoder tree; SHALL be >= 2.
REQ-003 Parameter LSB_FIRST, default 1: scan order; 1 = ascending index, 0 = descending index.
REQ-004 Local parameter WIDTH_LOG SHALL equal $clog2(WIDTH).
REQ-005 Port clk  input  1  single clock; all state changes occur on its rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port dec_vld  input  WIDTH  request vector, one bit per index.
REQ-008 Port dec_valid  input  1  request vector present.
REQ-009 Port dec_ready  output  1  block accepts a request vector.
REQ-010 Port enc_idx  output  WIDTH_LOG  index of the current set bit.
REQ-011 Port enc_lst  output  1  current beat is the last beat for its vector.
REQ-012 Port enc_nul  output  1  current beat carries no index; see Configuration.
REQ-013 Port enc_valid  output  1  output beat present.
REQ-014 Port enc_ready  input  1  downstream accepts the beat.

Function
REQ-015 A transfer SHALL occur on either side only in a cycle where valid and ready are both 1 at the rising clk edge.
REQ-016 The block SHALL hold a WIDTH-bit mask register and a two-state FSM: IDLE (mask empty) and SCAN (mask non-zero, or a pending null beat).
REQ-017 dec_ready SHALL be 1 in IDLE, and in SCAN only when enc_valid & enc_ready & enc_lst; otherwise it SHALL be 0.
REQ-018 On an accepted non-zero vector, the mask SHALL load dec_vld and the FSM SHALL enter SCAN; the first beat SHALL appear the next cycle (latency 1).
REQ-019 In SCAN, enc_valid SHALL be 1 and enc_idx SHALL be the lowest (LSB_FIRST=1) or highest (LSB_FIRST=0) set mask bit, encoded combinationally from the mask register only.
REQ-020 enc_lst SHALL be 1 when exactly one mask bit is set.
REQ-021 On each output transfer, the reported bit SHALL be cleared from the mask; if it was the last bit and no new vector is accepted in the same cycle, the FSM SHALL return to IDLE.
REQ-022 When the last beat and a new vector transfer in the same cycle, the new vector SHALL be loaded and SCAN retained, giving one beat per cycle with no bubble.
REQ-023 While enc_valid=1 and enc_ready=0, enc_idx, enc_lst and enc_nul SHALL hold stable.
REQ-024 X bits in dec_vld above the first set bit in scan order are undefined behaviour; the bench SHALL NOT check beats after the first in that case.

Reset
REQ-025 While rst_n=0, the mask SHALL clear immediately and the FSM SHALL be IDLE: enc_valid=0, enc_lst=0, enc_nul=0, enc_idx=0, dec_ready=1.
REQ-026 Reset asserted mid-scan SHALL discard all remaining beats; no beat from that vector SHALL appear after reset release.

Configuration
REQ-027 Macro PRIORITY_ENCODER_STREAM_NULL_EN SHALL control all-zero vectors.
REQ-028 With the macro defined, an accepted all-zero vector SHALL produce exactly one beat with enc_nul=1, enc_lst=1, enc_idx=0, with latency and handshake as REQ-018/REQ-022.
REQ-029 With the macro undefined, an accepted all-zero vector SHALL be consumed with no output beat, the FSM SHALL stay in or return to IDLE, and enc_nul SHALL be tied to 0.

Verification
REQ-030 After reset, dec_vld=16'h8421 with enc_ready=1 -> beats idx 0,5,10,15 on consecutive cycles, enc_lst=1 only on 15, dec_ready=1 in the cycle of the 15 beat.
REQ-031 Same vector with enc_ready=0 for 3 cycles on beat 5 -> idx 5 held stable for 3 cycles, then 10 and 15 follow with no loss or duplication.
REQ-032 Vectors 16'h0003 then 16'h8000 offered back-to-back with enc_ready=1 -> beats 0, 1 (lst), 15 (lst) in 3 consecutive cycles, no bubble.
REQ-033 LSB_FIRST=0, dec_vld=16'h0101 -> beats 8 then 0 (lst).
REQ-034 dec_vld=16'h0000 -> macro defined: one beat enc_nul=1 enc_lst=1; macro undefined: no beat, dec_ready stays 1.
REQ-035 rst_n driven low while the 16'h8421 scan is on beat 5 -> enc_valid=0 without waiting for a clk edge, and no further beats after release.
